// File: rtl/captura_numero.sv
// captura_numero: samples an 11x11 patch from a raster pixel stream. Each cell is the floor mean
// of a 2^SCALE_LOG2-square block of source pixels; the finished patch is held under valid/ready.
module captura_numero #(
   parameter int SCALE_LOG2 = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [9:0]             orig_x,
   input  logic [9:0]             orig_y,
   input  logic                   pix_valid,
   input  logic [9:0]             pix_x,
   input  logic [9:0]             pix_y,
   input  logic [7:0]             pix_data,
   input  logic                   patch_ready,
   output logic [10:0][10:0][7:0] numero,
   output logic                   patch_valid,
   output logic                   busy,
   output logic [1:0]             dbg_state
);
   localparam int S  = SCALE_LOG2;
   localparam int AW = 8 + 2 * S;
   localparam logic [10:0] WIN = 11'(11 << S);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [9:0]    ox, oy;
   logic [AW-1:0] acc [11];
   logic [10:0]   dx, dy;
   logic [3:0]    col, row;
   logic          in_win, close, hit, last_cell;
   logic [AW-1:0] acc_sel, sum;

   // Window geometry is evaluated in 11 bits so an origin near 1023 cannot wrap into range.
   always_comb begin
      dx      = {1'b0, pix_x} - {1'b0, ox};
      dy      = {1'b0, pix_y} - {1'b0, oy};
      in_win  = pix_valid && (pix_x >= ox) && (dx < WIN) && (pix_y >= oy) && (dy < WIN);
      col     = dx[S+3:S];
      row     = dy[S+3:S];
      close   = (&dx[S-1:0]) && (&dy[S-1:0]);
      acc_sel = '0;
      for (int c = 0; c < 11; c++) begin
         if (col == 4'(c)) acc_sel = acc[c];
      end
      sum       = acc_sel + AW'(pix_data);
      hit       = (state == CAPTURE) && in_win;
      last_cell = hit && close && (row == 4'd10) && (col == 4'd10);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CAPTURE;
         CAPTURE: if (last_cell) state_nxt = HOLD;
         HOLD:    if (patch_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // One accumulator per column: a raster row of cells is summed left to right, and each
   // accumulator is emptied as its cell's bottom-right pixel arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ox     <= '0;
         oy     <= '0;
         numero <= '0;
         for (int c = 0; c < 11; c++) acc[c] <= '0;
      end else if (abort) begin
         for (int c = 0; c < 11; c++) acc[c] <= '0;
      end else if (state == IDLE && start) begin
         ox <= orig_x;
         oy <= orig_y;
         for (int c = 0; c < 11; c++) acc[c] <= '0;
      end else if (hit) begin
         for (int c = 0; c < 11; c++) begin
            if (col == 4'(c)) begin
               if (close) begin
                  acc[c] <= '0;
                  for (int r = 0; r < 11; r++) begin
                     if (row == 4'(r)) numero[r][c] <= sum[AW-1:2*S];
                  end
               end else begin
                  acc[c] <= sum;
               end
            end
         end
      end
   end

   // Handshake: the patch transfers on any rising edge where patch_valid and patch_ready are both 1.
   assign patch_valid = (state == HOLD);
   assign busy        = (state != IDLE);
   assign dbg_state   = state;
endmodule

// File: tb/tb_captura_numero.sv
// Bench for captura_numero: table of capture scenarios streamed over a raster window, with
// per-cell expectations queued at the closing beat and checked the following half cycle.
module tb_captura_numero;
   localparam int W = 48;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic pix_valid = 1'b0, patch_ready = 1'b0;
   logic [9:0] orig_x = '0, orig_y = '0, pix_x = '0, pix_y = '0;
   logic [7:0] pix_data = '0;
   logic [10:0][10:0][7:0] numero;
   logic patch_valid, busy;
   logic [1:0] dbg_state;

   int total = 0, bad = 0, edge_cnt = 0;
   logic [W-1:0] exp_q[$];
   logic [7:0] exp_num [11][11];
   logic [7:0] rnd_img [64][64];

   typedef struct {
      int ox, oy, pat, val, ydrive, glitch, done, hold_n, exp00, exp1010;
   } cap_t;
   cap_t tbl [6];

   captura_numero #(.SCALE_LOG2(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .orig_x(orig_x), .orig_y(orig_y), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
      .patch_ready(patch_ready), .numero(numero), .patch_valid(patch_valid),
      .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int pix_fn(int pat, int val, int x, int y, int ox, int oy);
      if (pat == 0) return val;
      if (pat == 1) return (x >= ox && x - ox < 44 && y >= oy && y - oy < 44) ? x - ox : 255;
      return int'(rnd_img[y % 64][x % 64]);
   endfunction

   function automatic int cell_mean(int pat, int val, int ox, int oy, int r, int c);
      int s;
      s = 0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            s += pix_fn(pat, val, ox + 4 * c + j, oy + 4 * r + i, ox, oy);
      return s / 16;
   endfunction

   task automatic compare_all(input string name);
      int nb;
      nb = 0;
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 11; c++)
            if (numero[r][c] != exp_num[r][c]) nb++;
      check(name, nb, 0);
   endtask

   // scoreboard: entry = {due_edge, row, col, value}; row 14/15 are patch_valid markers
   logic [W-1:0] mon_e;
   int mon_r, mon_c;
   always @(negedge clk) begin
      while (exp_q.size() > 0 && int'(exp_q[0][47:16]) <= edge_cnt) begin
         mon_e = exp_q.pop_front();
         mon_r = int'(mon_e[15:12]);
         mon_c = int'(mon_e[11:8]);
         if (mon_r == 15)      check("pv_rise", patch_valid, 1);
         else if (mon_r == 14) check("pv_early", patch_valid, 0);
         else                  check($sformatf("cell_%0d_%0d", mon_r, mon_c),
                                     numero[mon_r][mon_c], int'(mon_e[7:0]));
      end
   end

   // driver tasks
   task automatic start_and_stream(input cap_t t);
      int x0, x1, y0, y1, dx, dy, m;
      bit done;
      start = 1'b1; orig_x = 10'(t.ox); orig_y = 10'(t.oy);
      tick;
      start = 1'b0;
      @(negedge clk); #1;
      check("busy_after_start", busy, 1);
      done = 1'b0;
      x0 = (t.ox >= 3) ? t.ox - 3 : 0;
      x1 = (t.ox + 46 > 1023) ? 1023 : t.ox + 46;
      y0 = (t.oy >= 2) ? t.oy - 2 : 0;
      y1 = (t.oy + t.ydrive - 1 > 1023) ? 1023 : t.oy + t.ydrive - 1;
      for (int y = y0; y <= y1; y++) begin
         for (int x = x0; x <= x1; x++) begin
            if ($urandom_range(0, 5) == 0) begin
               pix_valid = 1'b0;
               tick;
            end
            pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
            pix_data = 8'(pix_fn(t.pat, t.val, x, y, t.ox, t.oy));
            if (t.glitch != 0 && y == t.oy + 20 && x == t.ox) begin
               start = 1'b1; orig_x = '0; orig_y = '0;
            end
            dx = x - t.ox; dy = y - t.oy;
            if (!done && dx >= 0 && dx < 44 && dy >= 0 && dy < 44 && dx % 4 == 3 && dy % 4 == 3) begin
               m = cell_mean(t.pat, t.val, t.ox, t.oy, dy / 4, dx / 4);
               exp_num[dy / 4][dx / 4] = 8'(m);
               exp_q.push_back({32'(edge_cnt + 1), 4'(dy / 4), 4'(dx / 4), 8'(m)});
               if (dy / 4 == 10 && dx / 4 == 9) exp_q.push_back({32'(edge_cnt + 1), 4'd14, 4'd0, 8'd0});
               if (dy / 4 == 10 && dx / 4 == 10) begin
                  exp_q.push_back({32'(edge_cnt + 1), 4'd15, 4'd0, 8'd1});
                  done = 1'b1;
               end
            end
            tick;
            start = 1'b0;
         end
      end
      pix_valid = 1'b0;
   endtask

   task automatic handshake(input int n, input int glitch);
      for (int i = 0; i < n; i++) begin
         tick;
         check("hold_valid", patch_valid, 1);
      end
      compare_all("hold_stable");
      patch_ready = 1'b1;
      if (glitch != 0) begin
         start = 1'b1; orig_x = '0; orig_y = '0;
      end
      tick;
      patch_ready = 1'b0; start = 1'b0;
      check("hs_valid_drop", patch_valid, 0);
      check("hs_busy_drop", busy, 0);
      tick;
      check("idle_stays", busy, 0);
   endtask

   task automatic do_abort;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("abort_valid", patch_valid, 0);
      check("abort_busy", busy, 0);
   endtask

   task automatic run_capture(input cap_t t);
      start_and_stream(t);
      @(negedge clk); #1;
      if (t.done != 0) begin
         check("done_valid", patch_valid, 1);
         if (t.exp00 >= 0)   check("cell00_table", numero[0][0], t.exp00);
         if (t.exp1010 >= 0) check("cell1010_table", numero[10][10], t.exp1010);
         compare_all("patch_full");
         handshake(t.hold_n, t.glitch);
      end else begin
         check("stall_valid", patch_valid, 0);
         check("stall_busy", busy, 1);
         do_abort;
         compare_all("after_abort");
      end
   endtask

   initial begin
      cap_t rt;
      int nz;
      tbl[0] = '{100, 50, 0, 200, 47, 1, 1, 10, 200, 200};
      tbl[1] = '{100, 50, 1, 0,   47, 0, 1, 0,  1,   41};
      tbl[2] = '{37,  3,  2, 0,   47, 0, 1, 2,  -1,  -1};
      tbl[3] = '{100, 50, 2, 0,   22, 0, 0, 0,  -1,  -1};
      tbl[4] = '{100, 50, 0, 77,  47, 0, 1, 1,  77,  77};
      tbl[5] = '{1000, 0, 2, 0,   48, 0, 0, 0,  -1,  -1};
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 64; c++) rnd_img[r][c] = 8'($urandom_range(0, 255));
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 11; c++) exp_num[r][c] = '0;

      #12;
      compare_all("reset_numero");
      check("reset_valid", patch_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_state", dbg_state, 0);
      #11 rst_n = 1'b1;
      tick;

      for (int i = 0; i < 6; i++) run_capture(tbl[i]);

      // asynchronous reset in the middle of a capture
      rt = '{100, 50, 0, 60, 10, 0, 0, 0, -1, -1};
      start_and_stream(rt);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      nz = 0;
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 11; c++)
            if (numero[r][c] != 8'd0) nz++;
      check("midrst_numero", nz, 0);
      check("midrst_valid", patch_valid, 0);
      check("midrst_busy", busy, 0);
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 11; c++) exp_num[r][c] = '0;
      #13 rst_n = 1'b1;
      tick;

      rt = '{0, 0, 0, 9, 47, 0, 1, 0, 9, 9};
      run_capture(rt);

      @(negedge clk); #1;
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
